spi_cfg_slave: RTL and testbench

- Serial configuration front-end directly upstream of digtop_xfire.
- Receives SPI (mode 0) frames from the chip pads, oversampled in the clk domain.
- Converts each frame into single-cycle register write/read strobes toward the digital top register bank, and shifts read data back on MISO.
- Only path by which the host programs digtop_xfire.

---
 rtl/spi_cfg_slave.sv | 219 +++++++++++++++++++++
 tb/tb_spi_cfg_slave.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_slave.sv
// SPI mode-0 configuration slave: oversamples the pad-side SPI bus in the clk domain
// and turns each frame into a single register write or read strobe.
`timescale 1ns/1ps
module spi_cfg_slave #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              srst,
  input  logic              enable,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data,
  output logic              frm_abort
);

  localparam int CNT_W = $clog2(ADDR_W + DATA_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_RD    = 3'd2,
    ST_WDATA = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                 state_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   sclk_d_r;
  logic [CNT_W-1:0]       bit_cnt_r;
  logic [ADDR_W-1:0]      cmd_sr_r;
  logic [DATA_W-1:0]      data_sr_r;
  logic [DATA_W-1:0]      tx_sr_r;
  logic [1:0]             rd_ph_r;
  logic                   wr_pend_r;

  logic cs_s;
  logic sclk_s;
  logic mosi_s;
  logic sclk_rise_s;
  logic sclk_fall_s;

  assign cs_s        = cs_sync_r[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_d_r;
  assign sclk_fall_s = ~sclk_s & sclk_d_r;

  // Pad synchronizers; reset values describe an idle, deselected bus.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      sclk_d_r    <= 1'b0;
    end else if (srst) begin
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      sclk_d_r    <= 1'b0;
    end else begin
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs_n};
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      sclk_d_r    <= sclk_s;
    end
  end

  // Frame FSM with registered strobes, address/data and MISO drive.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= '0;
      cmd_sr_r  <= '0;
      data_sr_r <= '0;
      tx_sr_r   <= '0;
      rd_ph_r   <= 2'd0;
      wr_pend_r <= 1'b0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      frm_abort <= 1'b0;
      addr      <= '0;
      wr_data   <= '0;
    end else if (srst) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= '0;
      cmd_sr_r  <= '0;
      data_sr_r <= '0;
      tx_sr_r   <= '0;
      rd_ph_r   <= 2'd0;
      wr_pend_r <= 1'b0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      frm_abort <= 1'b0;
      addr      <= '0;
      wr_data   <= '0;
    end else begin
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      frm_abort <= 1'b0;
      if (!enable) begin
        state_r   <= ST_IDLE;
        bit_cnt_r <= '0;
        rd_ph_r   <= 2'd0;
        wr_pend_r <= 1'b0;
        miso      <= 1'b0;
        miso_oe   <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            miso    <= 1'b0;
            miso_oe <= 1'b0;
            if (!cs_s) begin
              state_r   <= ST_CMD;
              bit_cnt_r <= '0;
            end
          end
          ST_CMD: begin
            if (cs_s) begin
              state_r   <= ST_IDLE;
              frm_abort <= 1'b1;
            end else if (sclk_rise_s) begin
              cmd_sr_r <= {cmd_sr_r[ADDR_W-2:0], mosi_s};
              if (bit_cnt_r == CNT_W'(ADDR_W)) begin
                // The R/W bit has reached the top of the command shifter here.
                addr      <= {cmd_sr_r[ADDR_W-2:0], mosi_s};
                bit_cnt_r <= '0;
                rd_ph_r   <= 2'd0;
                wr_pend_r <= 1'b0;
                state_r   <= cmd_sr_r[ADDR_W-1] ? ST_RD : ST_WDATA;
              end else begin
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              end
            end
          end
          ST_RD: begin
            if (cs_s) begin
              state_r   <= ST_IDLE;
              frm_abort <= 1'b1;
              miso      <= 1'b0;
              miso_oe   <= 1'b0;
            end else begin
              case (rd_ph_r)
                2'd0: begin
                  rd_en   <= 1'b1;
                  rd_ph_r <= 2'd1;
                end
                2'd1: rd_ph_r <= 2'd2;
                2'd2: begin
                  tx_sr_r <= rd_data;
                  miso_oe <= 1'b1;
                  rd_ph_r <= 2'd3;
                end
                default: begin
                  if (sclk_fall_s) begin
                    miso    <= tx_sr_r[DATA_W-1];
                    tx_sr_r <= {tx_sr_r[DATA_W-2:0], 1'b0};
                    if (bit_cnt_r == CNT_W'(DATA_W - 1)) begin
                      state_r <= ST_DONE;
                    end else begin
                      bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    end
                  end
                end
              endcase
            end
          end
          ST_WDATA: begin
            if (cs_s) begin
              state_r   <= ST_IDLE;
              frm_abort <= 1'b1;
              wr_pend_r <= 1'b0;
            end else if (wr_pend_r) begin
              wr_en     <= 1'b1;
              wr_pend_r <= 1'b0;
              state_r   <= ST_DONE;
            end else if (sclk_rise_s) begin
              data_sr_r <= {data_sr_r[DATA_W-2:0], mosi_s};
              if (bit_cnt_r == CNT_W'(DATA_W - 1)) begin
                wr_data   <= {data_sr_r[DATA_W-2:0], mosi_s};
                wr_pend_r <= 1'b1;
              end else begin
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              end
            end
          end
          ST_DONE: begin
            if (cs_s) begin
              state_r <= ST_IDLE;
              miso    <= 1'b0;
              miso_oe <= 1'b0;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_cfg_slave.sv
// Scoreboard bench for spi_cfg_slave: a host drives SPI frames, expected strobes are
// queued, and a monitor pops and compares each strobe the DUT emits.
`timescale 1ns/1ps
module tb_spi_cfg_slave;

  localparam int HALF  = 40;
  localparam int EV_WR = 0;
  localparam int EV_RD = 1;
  localparam int EV_AB = 2;

  logic        clk = 1'b0;
  logic        arst, srst, enable, sclk, cs_n, mosi;
  logic        miso, miso_oe, wr_en, rd_en, frm_abort;
  logic [6:0]  addr;
  logic [15:0] wr_data, rd_data;

  typedef struct {
    int          kind;
    logic [6:0]  addr;
    logic [15:0] data;
  } ev_t;

  ev_t         exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] rx;
  logic        oe_and, oe_or;
  logic [15:0] rd_value;

  always #5 clk = ~clk;

  spi_cfg_slave #(.ADDR_W(7), .DATA_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .arst(arst), .srst(srst), .enable(enable),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .frm_abort(frm_abort)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
    end
  endtask

  function automatic logic [2:0] ev_flags(input int kind);
    case (kind)
      EV_WR:   ev_flags = 3'b100;
      EV_RD:   ev_flags = 3'b010;
      default: ev_flags = 3'b001;
    endcase
  endfunction

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin : mon
    ev_t         e;
    logic [2:0]  fl;
    logic [31:0] act_w, exp_w;
    fl = {wr_en, rd_en, frm_abort};
    if (fl != 3'b000) begin
      check("strobe_onehot", $countones(fl), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_event", {29'h0, fl}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        act_w = {6'h0, fl, addr, (e.kind == EV_RD) ? 16'h0 : wr_data};
        exp_w = {6'h0, ev_flags(e.kind), e.addr, (e.kind == EV_RD) ? 16'h0 : e.data};
        check("event", act_w, exp_w);
      end
    end
  end

  // Register bank model: read data appears two clocks after rd_en.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_en === 1'b1) begin
        @(posedge clk);
        #1 rd_data = rd_value;
      end
    end
  end

  task automatic spi_bits(input int n, input logic [31:0] v);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      #HALF;
      sclk   = 1'b1;
      rx     = {rx[30:0], miso};
      oe_and = oe_and & miso_oe;
      oe_or  = oe_or | miso_oe;
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic write_frame(input logic [6:0] a, input logic [15:0] d, input int extra);
    exp_q.push_back('{kind: EV_WR, addr: a, data: d});
    cs_n = 1'b0;
    #(2*HALF);
    oe_or = 1'b0;
    spi_bits(24, {8'h00, 1'b0, a, d});
    if (extra > 0) spi_bits(extra, 32'hFFFF_FFFF);
    #(2*HALF);
    cs_n = 1'b1;
    #(4*HALF);
    check("write_oe_low", {31'h0, oe_or}, 32'h0);
  endtask

  task automatic read_frame(input logic [6:0] a, input logic [15:0] d);
    exp_q.push_back('{kind: EV_RD, addr: a, data: 16'h0000});
    rd_value = d;
    rd_data  = 16'hDEAD;
    cs_n = 1'b0;
    #(2*HALF);
    spi_bits(8, {24'h0, 1'b1, a});
    oe_and = 1'b1;
    rx = 32'h0;
    spi_bits(16, 32'h0);
    check("read_miso", {16'h0, rx[15:0]}, {16'h0, d});
    check("read_oe_high", {31'h0, oe_and}, 32'h1);
    #(2*HALF);
    cs_n = 1'b1;
    #(4*HALF);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  initial begin
    arst = 1'b1; srst = 1'b0; enable = 1'b1;
    cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    rd_data = 16'hDEAD; rd_value = 16'h0; rx = 32'h0; oe_and = 1'b1; oe_or = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", {4'h0, miso, miso_oe, wr_en, rd_en, frm_abort, addr, wr_data}, 32'h0);
    arst = 1'b0;
    #(2*HALF);

    // Plain write.
    write_frame(7'h15, 16'hA5C3, 0);

    // Write truncated after 10 data bits; addr reloads the same value, wr_data untouched.
    exp_q.push_back('{kind: EV_AB, addr: 7'h15, data: 16'hA5C3});
    cs_n = 1'b0;
    #(2*HALF);
    spi_bits(18, {8'h00, 1'b0, 7'h15, 16'h5A5A} >> 6);
    #(2*HALF);
    cs_n = 1'b1;
    #(4*HALF);

    // Read with bank data returned two clocks after rd_en.
    read_frame(7'h7F, 16'h1234);

    // Write followed by surplus clocks.
    write_frame(7'h01, 16'h0001, 5);

    // Frame killed by enable low, then a clean write.
    cs_n = 1'b0;
    #(2*HALF);
    spi_bits(12, {20'h0, 1'b0, 7'h15, 4'hF});
    enable = 1'b0;
    spi_bits(12, 32'h0000_0FFF);
    #(2*HALF);
    cs_n = 1'b1;
    #(2*HALF);
    enable = 1'b1;
    #(2*HALF);
    write_frame(7'h33, 16'h5AA5, 0);

    // Asynchronous reset in the middle of a read data phase.
    exp_q.push_back('{kind: EV_RD, addr: 7'h10, data: 16'h0000});
    rd_value = 16'hC0DE;
    rd_data  = 16'hDEAD;
    cs_n = 1'b0;
    #(2*HALF);
    spi_bits(8, {24'h0, 1'b1, 7'h10});
    spi_bits(6, 32'h0);
    #1;
    arst = 1'b1;
    #1;
    check("arst_outputs", {4'h0, miso, miso_oe, wr_en, rd_en, frm_abort, addr, wr_data}, 32'h0);
    cs_n = 1'b1;
    #78;
    arst = 1'b0;
    #(2*HALF);
    write_frame(7'h02, 16'hBEEF, 0);

    #400;
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
